rv32_alu_decode: RTL and testbench



---
 rtl/rv32_alu_pkg.sv | 18 +
 rtl/rv32_alu_decode_skid.sv | 46 ++++
 rtl/rv32_alu_decode.sv | 87 ++++++++
 tb/tb_rv32_alu_decode.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_alu_pkg.sv
// rv32_alu_pkg: ALU op codes, opcodes and decoded bundle shared by decode and ALU
package rv32_alu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_ADDI, ALU_ANDI, ALU_ORI, ALU_XORI, ALU_SLT, ALU_SLTU, ALU_SLTI, ALU_SLTIU
    } alu_op_e;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    typedef struct packed {
        alu_op_e     opsel;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_bundle_t;
endpackage

// File: rtl/rv32_alu_decode_skid.sv
// rv32_skid_buf: 2-entry valid/ready buffer (output register + skid entry) for dec_bundle_t
module rv32_skid_buf
    import rv32_alu_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  dec_bundle_t in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output dec_bundle_t out_data
);
    logic        r_out_valid;
    logic        r_sk_valid;
    dec_bundle_t r_out;
    dec_bundle_t r_sk;
    logic        w_out_free;
    logic        w_acc;

    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = SKID_EN ? !r_sk_valid : w_out_free;
    assign w_acc      = in_valid && in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out;

    // skid entry only fills while the output is stalled, so it always refills the output first
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_out_valid <= 1'b0;
            r_sk_valid  <= 1'b0;
            r_out       <= '0;
            r_sk        <= '0;
        end else if (w_out_free) begin
            r_out_valid <= r_sk_valid || w_acc;
            r_out       <= r_sk_valid ? r_sk : w_acc ? in_data : r_out;
            r_sk_valid  <= 1'b0;
        end else if (w_acc) begin
            r_sk_valid  <= 1'b1;
            r_sk        <= in_data;
        end
    end
endmodule

// File: rtl/rv32_alu_decode.sv
// rv32_alu_decode: RV32I OP/OP-IMM decoder with skid output; RV32_DEC_ILLEGAL_CHECK_EN enables strict funct7/opcode checks
module rv32_alu_decode
    import rv32_alu_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_opsel,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        illegal
);
    function automatic dec_bundle_t decode(input logic [31:0] ins);
        dec_bundle_t d;
        logic [2:0]  f3;
        logic        is_op;
        logic        is_imm;
        logic        is_shift;
        logic        alt;
        logic        bad;
        f3       = ins[14:12];
        is_op    = ins[6:0] == OPC_OP;
        is_imm   = ins[6:0] == OPC_OP_IMM;
        is_shift = is_imm && f3[1:0] == 2'b01;
        alt      = ins[30];
        d.rd      = ins[11:7];
        d.rs1     = ins[19:15];
        d.rs2     = is_imm ? 5'd0 : ins[24:20];
        d.use_imm = is_imm;
        d.imm     = is_shift ? {27'd0, ins[24:20]} : is_imm ? {{20{ins[31]}}, ins[31:20]} : 32'd0;
        case (f3)
            3'b000:  d.opsel = is_imm ? ALU_ADDI : alt ? ALU_SUB : ALU_ADD;
            3'b001:  d.opsel = ALU_SLL;
            3'b010:  d.opsel = is_imm ? ALU_SLTI : ALU_SLT;
            3'b011:  d.opsel = is_imm ? ALU_SLTIU : ALU_SLTU;
            3'b100:  d.opsel = is_imm ? ALU_XORI : ALU_XOR;
            3'b101:  d.opsel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  d.opsel = is_imm ? ALU_ORI : ALU_OR;
            default: d.opsel = is_imm ? ALU_ANDI : ALU_AND;
        endcase
`ifdef RV32_DEC_ILLEGAL_CHECK_EN
        // funct7 is immediate bits for non-shift OP-IMM, so only OP and shifts are checked
        bad = !(is_op || is_imm) || ((is_op || is_shift) && ins[31:25] != 7'b0000000 &&
              !(ins[31:25] == 7'b0100000 && (f3 == 3'b101 || (is_op && f3 == 3'b000))));
`else
        bad = 1'b0;
`endif
        d.illegal = bad;
        d.opsel   = (bad || !(is_op || is_imm)) ? ALU_ADD : d.opsel;
        return d;
    endfunction

    dec_bundle_t w_dec;
    dec_bundle_t w_out;

    assign w_dec = decode(in_instr);

    rv32_skid_buf #(.SKID_EN(SKID_EN)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out)
    );

    assign alu_opsel = w_out.opsel;
    assign use_imm   = w_out.use_imm;
    assign imm       = w_out.imm;
    assign rs1       = w_out.rs1;
    assign rs2       = w_out.rs2;
    assign rd        = w_out.rd;
    assign illegal   = w_out.illegal;
endmodule

// File: tb/tb_rv32_alu_decode.sv
// tb_rv32_alu_decode: scoreboard bench for rv32_alu_decode, aware of RV32_DEC_ILLEGAL_CHECK_EN
module tb_rv32_alu_decode;
    import rv32_alu_pkg::*;

`ifdef RV32_DEC_ILLEGAL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [2:0] F3_T [19] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5, 3'd0, 3'd7,
                                         3'd6, 3'd4, 3'd2, 3'd3, 3'd2, 3'd3, 3'd1, 3'd5, 3'd5};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  alu_opsel;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
    dec_bundle_t exp_in = '0;
    dec_bundle_t q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          armed = 1'b0;
    bit          sb_acc;

    always #5 clk = ~clk;

    rv32_alu_decode dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .alu_opsel(alu_opsel),
        .use_imm(use_imm), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .illegal(illegal)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic dec_bundle_t dut_bundle();
        dec_bundle_t b;
        b.opsel = alu_op_e'(alu_opsel);
        b.use_imm = use_imm;
        b.imm = imm;
        b.rs1 = rs1;
        b.rs2 = rs2;
        b.rd = rd;
        b.illegal = illegal;
        return b;
    endfunction

    function automatic dec_bundle_t mk(input int op, input bit ui, input logic [31:0] im,
                                       input int s1, input int s2, input int d, input bit il);
        dec_bundle_t b;
        b.opsel = alu_op_e'(4'(op));
        b.use_imm = ui;
        b.imm = im;
        b.rs1 = 5'(s1);
        b.rs2 = 5'(s2);
        b.rd = 5'(d);
        b.illegal = il;
        return b;
    endfunction

    // Encoder: mnemonic index 0..15 = opsel code, 16/17/18 = SLLI/SRLI/SRAI
    task automatic enc(input int m, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [11:0] i12, output logic [31:0] ins, output dec_bundle_t e);
        bit         im;
        bit         sh;
        logic [6:0] f7;
        im = m inside {[8:11], [14:18]};
        sh = m inside {[16:18]};
        f7 = (m inside {1, 7, 18}) ? 7'h20 : 7'h00;
        ins = (im && !sh) ? {i12, s1, F3_T[m], d, 7'b0010011}
                          : {f7, s2, s1, F3_T[m], d, im ? 7'b0010011 : 7'b0110011};
        e.opsel = alu_op_e'(4'(m < 16 ? m : m - 11));
        e.use_imm = im;
        e.imm = sh ? {27'd0, s2} : im ? {{20{i12[11]}}, i12} : 32'd0;
        e.rs1 = s1;
        e.rs2 = im ? 5'd0 : s2;
        e.rd = d;
        e.illegal = 1'b0;
    endtask

    // Occupancy/order model: queue of bundles held in the stage, at most two
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            armed = 1'b1;
        end else if (armed) begin
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (q.size() != 0) chk("bundle", dut_bundle(), q[0]);
            sb_acc = in_valid && q.size() < 2;
            if (flush) q.delete();
            else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (sb_acc) q.push_back(exp_in);
            end
        end
    end

    task automatic one(input string nm, input logic [31:0] ins, input dec_bundle_t e);
        in_valid = 1'b1;
        in_instr = ins;
        exp_in = e;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_valid"}, out_valid, 1);
        chk(nm, dut_bundle(), e);
    endtask

    task automatic send(input logic [31:0] ins, input dec_bundle_t e);
        int k;
        in_valid = 1'b1;
        in_instr = ins;
        exp_in = e;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) chk("send_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] ia, ib, ic, iw;
        dec_bundle_t ea, eb, ec, ew;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_data", dut_bundle(), 0);
        @(posedge clk); #1;

        enc(2, 5'd3, 5'd1, 5'd2, 12'd0, iw, ew);
        chk("enc_and", iw, 32'h0020F1B3);
        chk("enc_and_exp", ew, mk(2, 0, 0, 1, 2, 3, 0));
        enc(10, 5'd5, 5'd6, 5'd0, 12'hFFF, iw, ew);
        chk("enc_ori", iw, 32'hFFF36293);
        enc(18, 5'd1, 5'd2, 5'd3, 12'd0, iw, ew);
        chk("enc_srai", iw, 32'h40315093);

        one("and", 32'h0020F1B3, mk(2, 0, 32'd0, 1, 2, 3, 0));
        one("ori", 32'hFFF36293, mk(10, 1, 32'hFFFFFFFF, 6, 0, 5, 0));
        one("srai", 32'h40315093, mk(7, 1, 32'd3, 2, 0, 1, 0));
        one("xor_f7", 32'h4020C1B3, CHK ? mk(0, 0, 0, 1, 2, 3, 1) : mk(4, 0, 0, 1, 2, 3, 0));
        one("mul_f7", 32'h022081B3, mk(0, 0, 0, 1, 2, 3, CHK));
        one("lui", 32'h123452B7, mk(0, 0, 0, 8, 3, 5, CHK));
        one("slli_f7", 32'h40311093, CHK ? mk(0, 1, 3, 2, 0, 1, 1) : mk(5, 1, 3, 2, 0, 1, 0));
        @(posedge clk); #1;

        enc(0, 5'd7, 5'd1, 5'd2, 12'd0, ia, ea);
        enc(9, 5'd8, 5'd3, 5'd0, 12'h80F, ib, eb);
        enc(6, 5'd9, 5'd4, 5'd5, 12'd0, ic, ec);
        out_ready = 1'b0;
        send(ia, ea);
        send(ib, eb);
        in_valid = 1'b1;
        in_instr = ic;
        exp_in = ec;
        @(negedge clk);
        chk("abc_held", in_ready, 0);
        chk("abc_head", rd, 7);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("abc_a", {out_valid, rd}, {1'b1, 5'd7});
        @(negedge clk);
        chk("abc_b", {out_valid, rd}, {1'b1, 5'd8});
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abc_c", {out_valid, rd}, {1'b1, 5'd9});
        @(posedge clk); #1;

        out_ready = 1'b0;
        send(ia, ea);
        send(ib, eb);
        @(negedge clk);
        chk("flush_full", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b1;
        in_valid = 1'b1;
        in_instr = ic;
        exp_in = ec;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(ia, ea);
        send(ib, eb);
        rst = 1'b1;
        in_valid = 1'b1;
        in_instr = ic;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_data", dut_bundle(), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            enc($urandom_range(0, 18), 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom), iw, ew);
            in_instr = iw;
            exp_in = ew;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 30) == 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
